// File: rtl/mmio_out_bank.sv
`default_nettype none
// ============================================================================
// Module      : mmio_out_bank
// Description : Bank of NCH memory-mapped output registers with DATA/SET/CLR/
//               PULSE write views, registered readback and timed auto-clear.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_out_bank #(
    parameter int             AW        = 15,
    parameter logic [AW-1:0]  BASE      = 15'h7000,
    parameter int             DW        = 16,
    parameter int             NCH       = 4,
    parameter int             PULSE_LEN = 50000,
    parameter int             CW        = 16
) (
    input  logic              clk50m,
    input  logic              rst,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     data_in,
    input  logic              we,
    input  logic              re,
    output logic [DW-1:0]     rdata,
    output logic              rvalid,
    output logic [NCH*DW-1:0] port_out,
    output logic [NCH-1:0]    pulse_busy
);

    localparam logic [AW-1:0] c_SPAN   = AW'(4 * NCH);
    localparam logic [CW-1:0] c_RELOAD = CW'(PULSE_LEN);
    localparam logic [CW-1:0] c_ONE    = CW'(1);

    localparam logic [1:0] c_K_DATA = 2'd0;
    localparam logic [1:0] c_K_SET  = 2'd1;
    localparam logic [1:0] c_K_CLR  = 2'd2;

    logic [AW-1:0] w_off;
    logic          w_hit;
    logic [AW-3:0] w_ch;
    logic [1:0]    w_k;
    logic [DW-1:0] w_chan [NCH];
    logic [DW-1:0] w_rd_mux;

    // Subtraction wraps below BASE, so the lower bound is checked explicitly.
    assign w_off = addr - BASE;
    assign w_hit = (addr >= BASE) && (w_off < c_SPAN);
    assign w_ch  = w_off[AW-1:2];
    assign w_k   = w_off[1:0];

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [DW-1:0] r_out;
            logic [DW-1:0] r_mask;
            logic [CW-1:0] r_cnt;
            logic          w_wr;

            assign w_wr = we && w_hit && (w_ch == (AW-2)'(c));

            // Any write to the channel takes priority over the timer, so a
            // write on the expiry cycle suppresses the auto-clear.
            always_ff @(posedge clk50m or posedge rst) begin
                if (rst) begin
                    r_out  <= '0;
                    r_mask <= '0;
                    r_cnt  <= '0;
                end else if (w_wr) begin
                    case (w_k)
                        c_K_DATA: begin
                            r_out  <= data_in;
                            r_mask <= '0;
                            r_cnt  <= '0;
                        end
                        c_K_SET: begin
                            r_out  <= r_out | data_in;
                            r_mask <= '0;
                            r_cnt  <= '0;
                        end
                        c_K_CLR: begin
                            r_out  <= r_out & ~data_in;
                            r_mask <= '0;
                            r_cnt  <= '0;
                        end
                        default: begin
                            r_out  <= r_out | data_in;
                            r_mask <= data_in;
                            r_cnt  <= c_RELOAD;
                        end
                    endcase
                end else if (r_cnt != '0) begin
                    if (r_cnt == c_ONE) begin
                        r_out  <= r_out & ~r_mask;
                        r_mask <= '0;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
            end

            assign w_chan[c]             = r_out;
            assign port_out[c*DW +: DW]  = r_out;
            assign pulse_busy[c]         = (r_cnt != '0);
        end
    endgenerate

    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_ch == (AW-2)'(c)) begin
                w_rd_mux = w_chan[c];
            end
        end
    end

    // Readback samples the pre-edge register, giving old data on a
    // simultaneous read and write.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (re && w_hit) begin
            rdata  <= w_rd_mux;
            rvalid <= 1'b1;
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_out_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_out_bank
// Description : Scoreboard bench for mmio_out_bank with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_out_bank;

    localparam logic [14:0] c_BASE = 15'h7000;

    logic        clk50m;
    logic        rst;
    logic [14:0] addr;
    logic [15:0] data_in;
    logic        we;
    logic        re;
    logic [15:0] rdata;
    logic        rvalid;
    logic [63:0] port_out;
    logic [3:0]  pulse_busy;

    int          n_vec;
    int          n_bad;
    logic [15:0] exp_q[$];
    logic [15:0] r_exp;

    mmio_out_bank #(
        .AW        (15),
        .BASE      (c_BASE),
        .DW        (16),
        .NCH       (4),
        .PULSE_LEN (5),
        .CW        (16)
    ) u_dut (
        .clk50m     (clk50m),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .we         (we),
        .re         (re),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .port_out   (port_out),
        .pulse_busy (pulse_busy)
    );

    initial clk50m = 1'b0;
    always #5 clk50m = ~clk50m;

    function automatic logic [14:0] a(input int c, input int k);
        return c_BASE + 15'(4 * c + k);
    endfunction

    function automatic logic [15:0] chv(input int c);
        return port_out[c*16 +: 16];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, sampled at the next rising edge.
    task automatic bus(input logic w, input logic r, input logic [14:0] ad, input logic [15:0] d);
        @(negedge clk50m);
        we      = w;
        re      = r;
        addr    = ad;
        data_in = d;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 15'h0, 16'h0);
    endtask

    task automatic rd(input logic [14:0] ad, input logic [15:0] e);
        bus(1'b0, 1'b1, ad, 16'h0);
        exp_q.push_back(e);
    endtask

    // Monitor: every read response is matched against the scoreboard queue.
    always @(negedge clk50m) begin
        if (!rst && rvalid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h, required no response", rdata);
            end else begin
                r_exp = exp_q.pop_front();
                if (rdata !== r_exp) begin
                    n_bad++;
                    $display("FAIL rdata: got %h, required %h", rdata, r_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        addr    = 15'h0;
        data_in = 16'h0;
        #1 rst  = 1'b1;
        repeat (2) @(negedge clk50m);
        chk("reset_port_out", port_out, 64'h0);
        chk("reset_busy", 64'(pulse_busy), 64'h0);
        chk("reset_rvalid", 64'(rvalid), 64'h0);
        chk("reset_rdata", 64'(rdata), 64'h0);
        rst = 1'b0;

        // Asynchronous reset in the middle of operation
        bus(1'b1, 1'b0, a(0, 0), 16'h1234);
        idle();
        chk("pre_reset_ch0", 64'(chv(0)), 64'h1234);
        #2 rst = 1'b1;
        #1 chk("async_reset_ch0", port_out, 64'h0);
        @(negedge clk50m);
        rst = 1'b0;

        // DATA write and readback
        bus(1'b1, 1'b0, a(0, 0), 16'hA5A5);
        idle();
        chk("data_ch0", 64'(chv(0)), 64'hA5A5);
        rd(a(0, 0), 16'hA5A5);
        idle();
        idle();
        chk("rvalid_one_cycle", 64'(rvalid), 64'h0);

        // SET / CLR and decode bounds
        bus(1'b1, 1'b0, a(1, 0), 16'h00F0);
        bus(1'b1, 1'b0, a(1, 1), 16'h0F00);
        bus(1'b1, 1'b0, a(1, 2), 16'h0030);
        idle();
        chk("set_clr_ch1", 64'(chv(1)), 64'h0FC0);
        bus(1'b1, 1'b0, c_BASE - 15'd1, 16'hFFFF);
        bus(1'b1, 1'b0, c_BASE + 15'd16, 16'hFFFF);
        idle();
        chk("miss_writes", port_out, 64'h0000_0000_0FC0_A5A5);
        rd(a(1, 2), 16'h0FC0);
        rd(a(1, 3), 16'h0FC0);
        bus(1'b0, 1'b1, c_BASE + 15'd16, 16'h0);
        bus(1'b0, 1'b1, c_BASE - 15'd1, 16'h0);
        idle();
        chk("miss_read_rvalid", 64'(rvalid), 64'h0);
        chk("miss_read_rdata_hold", 64'(rdata), 64'h0FC0);

        // Pulse exact width on channel 2
        bus(1'b1, 1'b0, a(2, 0), 16'h0001);
        bus(1'b1, 1'b0, a(2, 3), 16'h8000);
        for (int j = 1; j <= 7; j++) begin
            idle();
            chk($sformatf("pulse_ch2_c%0d", j), 64'(chv(2)), (j <= 5) ? 64'h8001 : 64'h0001);
            chk($sformatf("busy_ch2_c%0d", j), 64'(pulse_busy[2]), (j <= 5) ? 64'h1 : 64'h0);
        end

        // Retrigger on channel 3
        bus(1'b1, 1'b0, a(3, 3), 16'h0001);
        idle();
        idle();
        bus(1'b1, 1'b0, a(3, 3), 16'h0002);
        for (int j = 1; j <= 6; j++) begin
            idle();
            chk($sformatf("retrig_ch3_c%0d", j), 64'(chv(3)), (j <= 5) ? 64'h0003 : 64'h0001);
        end

        // SET during a pulse cancels the auto-clear
        bus(1'b1, 1'b0, a(3, 3), 16'h0010);
        idle();
        idle();
        bus(1'b1, 1'b0, a(3, 1), 16'h0004);
        for (int j = 1; j <= 6; j++) begin
            idle();
            chk($sformatf("cancel_ch3_c%0d", j), 64'(chv(3)), 64'h0015);
            chk($sformatf("cancel_busy_c%0d", j), 64'(pulse_busy[3]), 64'h0);
        end

        // Simultaneous read and write returns the old value
        bus(1'b1, 1'b1, a(0, 0), 16'h1111);
        exp_q.push_back(16'hA5A5);
        idle();
        chk("rw_same_cycle_port", 64'(chv(0)), 64'h1111);

        // DATA write on the expiry edge wins over the clear
        bus(1'b1, 1'b0, a(2, 3), 16'h0100);
        repeat (4) idle();
        chk("expiry_pre_busy", 64'(pulse_busy[2]), 64'h1);
        bus(1'b1, 1'b0, a(2, 0), 16'h0100);
        for (int j = 1; j <= 3; j++) begin
            idle();
            chk($sformatf("expiry_write_ch2_c%0d", j), 64'(chv(2)), 64'h0100);
            chk($sformatf("expiry_busy_c%0d", j), 64'(pulse_busy[2]), 64'h0);
        end

        // Reset during an active pulse
        bus(1'b1, 1'b0, a(3, 3), 16'h00F0);
        idle();
        chk("rst_pulse_busy_before", 64'(pulse_busy[3]), 64'h1);
        #2 rst = 1'b1;
        #1 chk("rst_pulse_port_out", port_out, 64'h0);
        chk("rst_pulse_busy", 64'(pulse_busy), 64'h0);
        @(negedge clk50m);
        rst = 1'b0;
        bus(1'b1, 1'b0, a(3, 0), 16'h00F2);
        for (int j = 1; j <= 6; j++) begin
            idle();
            chk($sformatf("post_rst_ch3_c%0d", j), 64'(chv(3)), 64'h00F2);
        end
        chk("post_rst_others", port_out[47:0], 48'h0);

        repeat (3) idle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL read_responses_missing: got %0d outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
